// File: rtl/io_pad_pkg.sv
// Shared constants and types for the pad-input conditioning slice.
package io_pad_pkg;

    // Legal synchroniser depth range.
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Default geometry of the pad ring slice.
    localparam int NUM_PADS_DEF = 8;
    localparam int FILT_W_DEF   = 4;

    typedef logic [NUM_PADS_DEF-1:0] pad_vec_t;
    typedef logic [FILT_W_DEF-1:0]   filt_cnt_t;

    // Keep an out-of-range depth from building a broken chain.
    function automatic int clamp_sync(input int n);
        if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
        if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
        return n;
    endfunction

endpackage

// File: rtl/io_pad_filt_cell.sv
// One pad: synchroniser chain, stability counter, filtered level flop and
// registered rise/fall pulses that change together with the filtered level.
module io_pad_filt_cell
    import io_pad_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_W      = 4,
    parameter logic RESET_BIT   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pad_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic              en_i,
    output logic              filt_o,
    output logic              rise_o,
    output logic              fall_o
);

    localparam int SS = clamp_sync(SYNC_STAGES);

    logic [SS-1:0]     sync_q;
    logic              s;
    logic [FILT_W-1:0] cnt_q;
    logic              filt_q;
    logic              rise_q;
    logic              fall_q;

    // Synchroniser chain; runs whether or not the filter is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {SS{RESET_BIT}};
        else        sync_q <= {sync_q[SS-2:0], pad_i};
    end

    assign s = sync_q[SS-1];

    // Stability filter: commit a new level once it has differed from the
    // held level for filt_len_i+1 consecutive cycles; pulses are one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            filt_q <= RESET_BIT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (!en_i) begin
                cnt_q <= '0;
            end else if (s == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q >= filt_len_i) begin
                // Compare against the live length so a lowered value commits at once.
                filt_q <= s;
                cnt_q  <= '0;
                rise_q <= s;
                fall_q <= ~s;
            end else if (!(&cnt_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign filt_o = filt_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/io_pad_in_filter.sv
// Pad-input conditioner: per-pad filter cells plus sticky edge status and irq.
module io_pad_in_filter
    import io_pad_pkg::*;
#(
    parameter int                  NUM_PADS    = NUM_PADS_DEF,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  FILT_W      = FILT_W_DEF,
    parameter logic [NUM_PADS-1:0] RESET_VAL   = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_PADS-1:0] pad_i,
    input  logic [FILT_W-1:0]   filt_len_i,
    input  logic [NUM_PADS-1:0] en_i,
    input  logic [NUM_PADS-1:0] rise_en_i,
    input  logic [NUM_PADS-1:0] fall_en_i,
    input  logic [NUM_PADS-1:0] clr_i,
    output logic [NUM_PADS-1:0] filt_o,
    output logic [NUM_PADS-1:0] rise_o,
    output logic [NUM_PADS-1:0] fall_o,
    output logic [NUM_PADS-1:0] evt_sts_o,
    output logic                irq_o
);

    logic [NUM_PADS-1:0] sts_q;
    logic [NUM_PADS-1:0] sts_set;
    logic [NUM_PADS-1:0] sts_nxt;
    logic                irq_q;

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        io_pad_filt_cell #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W),
            .RESET_BIT   (RESET_VAL[i])
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .pad_i      (pad_i[i]),
            .filt_len_i (filt_len_i),
            .en_i       (en_i[i]),
            .filt_o     (filt_o[i]),
            .rise_o     (rise_o[i]),
            .fall_o     (fall_o[i])
        );
    end

    // A new event beats a same-cycle clear so no edge is ever lost.
    assign sts_set = (rise_o & rise_en_i) | (fall_o & fall_en_i);
    assign sts_nxt = sts_set | (sts_q & ~clr_i);

    // Sticky status; irq is registered from the next status so both move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sts_q <= '0;
            irq_q <= 1'b0;
        end else begin
            sts_q <= sts_nxt;
            irq_q <= |sts_nxt;
        end
    end

    assign evt_sts_o = sts_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_io_pad_in_filter.sv
// Bench for io_pad_in_filter: directed plan steps followed by random traffic,
// every cycle compared against a behavioural model of the pad conditioner.
module tb_io_pad_in_filter;

    localparam int N  = 8;
    localparam int SS = 2;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  pad_i = '1;
    logic [FW-1:0] filt_len_i = 4'd3;
    logic [N-1:0]  en_i = '1;
    logic [N-1:0]  rise_en_i = '1;
    logic [N-1:0]  fall_en_i = '0;
    logic [N-1:0]  clr_i = '0;
    logic [N-1:0]  filt_o, rise_o, fall_o, evt_sts_o;
    logic          irq_o;

    io_pad_in_filter #(
        .NUM_PADS    (N),
        .SYNC_STAGES (SS),
        .FILT_W      (FW),
        .RESET_VAL   ('0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pad_i      (pad_i),
        .filt_len_i (filt_len_i),
        .en_i       (en_i),
        .rise_en_i  (rise_en_i),
        .fall_en_i  (fall_en_i),
        .clr_i      (clr_i),
        .filt_o     (filt_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .evt_sts_o  (evt_sts_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: pad samples seen by the filter are pad_i delayed SS clocks;
    // each pad commits a new level after a streak of filt_len+1 differing,
    // enabled samples.
    logic [N-1:0] padq[$];
    logic [N-1:0] m_filt, m_rise, m_fall, m_sts;
    logic         m_irq;
    int           streak[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        padq.delete();
        for (int k = 0; k < SS; k++) padq.push_back('0);
        m_filt = '0; m_rise = '0; m_fall = '0; m_sts = '0; m_irq = 1'b0;
        for (int k = 0; k < N; k++) streak[k] = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] s, nr, nf;
        s = padq[SS-1];
        m_sts = (m_rise & rise_en_i) | (m_fall & fall_en_i) | (m_sts & ~clr_i);
        m_irq = (m_sts != '0);
        nr = '0; nf = '0;
        for (int k = 0; k < N; k++) begin
            if (!en_i[k] || s[k] == m_filt[k]) begin
                streak[k] = 0;
            end else if (streak[k] >= int'(filt_len_i)) begin
                m_filt[k] = s[k];
                streak[k] = 0;
                if (s[k]) nr[k] = 1'b1; else nf[k] = 1'b1;
            end else if (streak[k] < (1 << FW) - 1) begin
                streak[k]++;
            end
        end
        m_rise = nr; m_fall = nf;
        padq.push_front(pad_i);
        void'(padq.pop_back());
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        chk("filt", filt_o, m_filt);
        chk("rise", rise_o, m_rise);
        chk("fall", fall_o, m_fall);
        chk("sts", evt_sts_o, m_sts);
        chk("irq", irq_o, m_irq);
    endtask

    initial begin
        int lat;
        int rcnt[N];
        int nrise, nfall;
        logic fall_seen, found;
        logic p1[0:31];

        model_reset();
        #2;
        // Reset state with pads all high.
        chk("rst_filt", filt_o, 8'h00);
        chk("rst_rise", rise_o, 8'h00);
        chk("rst_fall", fall_o, 8'h00);
        chk("rst_sts", evt_sts_o, 8'h00);
        chk("rst_irq", irq_o, 1'b0);
        tick();
        rst_n = 1'b1;

        // Release with pads high, len 3: filt rises after 2+3+1 clocks.
        lat = -1; fall_seen = 1'b0;
        for (int k = 0; k < N; k++) rcnt[k] = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (lat < 0 && filt_o == 8'hFF) lat = k;
            for (int b = 0; b < N; b++) rcnt[b] += int'(rise_o[b]);
            fall_seen |= (fall_o != '0);
        end
        chk("rel_lat", lat, 6);
        for (int b = 0; b < N; b++) chk("rel_one_rise", rcnt[b], 1);
        chk("rel_no_fall", fall_seen, 1'b0);
        chk("rel_irq", irq_o, 1'b1);

        clr_i = '1; tick(); clr_i = '0;
        rise_en_i = '0;

        // len 4: a 4-cycle low glitch on pad 0 is discarded.
        filt_len_i = 4'd4;
        pad_i[0] = 1'b0;
        repeat (4) tick();
        pad_i[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("glitch_filt0", filt_o[0], 1'b1);
            chk("glitch_fall0", fall_o[0], 1'b0);
        end
        // A held level commits 2+4+1 clocks after the change.
        pad_i[0] = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (lat < 0 && filt_o[0] == 1'b0) lat = k;
        end
        chk("lat_len4", lat, 7);

        // len 0: pad 1 toggled every 2 clocks, filt follows 3 clocks later.
        filt_len_i = 4'd0;
        nrise = 0; nfall = 0;
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) pad_i[1] = ~pad_i[1];
            p1[k] = pad_i[1];
            tick();
            if (k >= 2) chk("follow1", filt_o[1], p1[k-2]);
            nrise += int'(rise_o[1]);
            nfall += int'(fall_o[1]);
        end
        chk("follow_rises", nrise, 3);
        chk("follow_falls", nfall, 4);

        // Rise-only capture on pad 2, then write-1-to-clear.
        filt_len_i = 4'd1;
        pad_i[2] = 1'b0;
        repeat (8) tick();
        clr_i = '1; tick(); clr_i = '0;
        rise_en_i = 8'h04; fall_en_i = 8'h00;
        pad_i[2] = 1'b1;
        repeat (8) tick();
        chk("rise_sts", evt_sts_o, 8'h04);
        chk("rise_irq", irq_o, 1'b1);
        pad_i[2] = 1'b0;
        repeat (8) tick();
        chk("fall_ignored", evt_sts_o, 8'h04);
        clr_i = 8'h04; tick(); clr_i = '0;
        chk("clr_sts", evt_sts_o, 8'h00);
        chk("clr_irq", irq_o, 1'b0);

        // Clear coinciding with a rise on pad 3: set wins.
        rise_en_i = 8'h08;
        pad_i[3] = 1'b0;
        repeat (8) tick();
        pad_i[3] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (rise_o[3]) found = 1'b1;
        end
        chk("rise3_seen", found, 1'b1);
        clr_i = 8'h08; tick(); clr_i = '0;
        chk("set_wins", evt_sts_o[3], 1'b1);
        clr_i = 8'h08; tick(); clr_i = '0;
        rise_en_i = '0;

        // Pad 4: enable dropped mid-count, full count needed after restore.
        filt_len_i = 4'd5;
        fall_en_i = 8'h10;
        pad_i[4] = 1'b0;
        repeat (4) tick();
        en_i[4] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("dis_filt4", filt_o[4], 1'b1);
            chk("dis_fall4", fall_o[4], 1'b0);
        end
        en_i[4] = 1'b1;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (lat < 0 && filt_o[4] == 1'b0) lat = k;
        end
        chk("reen_lat", lat, 6);
        chk("reen_sts4", evt_sts_o[4], 1'b1);

        // Async reset mid-count takes effect inside the cycle.
        filt_len_i = 4'd6;
        pad_i[5] = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_filt", filt_o, 8'h00);
        chk("arst_rise", rise_o, 8'h00);
        chk("arst_fall", fall_o, 8'h00);
        chk("arst_sts", evt_sts_o, 8'h00);
        chk("arst_irq", irq_o, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rel_no_pulse", rise_o | fall_o, 8'h00);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            if (k % 60 == 0) filt_len_i = 4'($urandom_range(0, 5));
            pad_i     = pad_i ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            en_i      = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
            rise_en_i = 8'($urandom);
            fall_en_i = 8'($urandom);
            clr_i     = 8'($urandom) & 8'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_pad_in_filter.md
Name: io_pad_in_filter

Overview:
- Conditions raw digital inputs coming off the EG1D80V pad ring before they enter core logic.
- Per pad: multi-flop synchroniser, then a programmable stability (glitch) filter, then rise/fall edge detection.
- Edge events are captured in a sticky status register with an OR-reduced interrupt.
- Sits directly downstream of the IO ring (pad cells, fillers, supply cells) and upstream of the GPIO/register block.

Parameters:
- NUM_PADS, 8: number of pad inputs handled.
- SYNC_STAGES, 2: synchroniser depth, legal range 2..4.
- FILT_W, 4: width of the filter-length field and of each per-pad counter.
- RESET_VAL, '0 (NUM_PADS bits): reset value of the synchroniser flops and the filtered outputs.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- pad_i  in  NUM_PADS  raw pad-cell outputs, asynchronous to clk.
- filt_len_i  in  FILT_W  required stable cycles minus 1; quasi-static, shared by all pads.
- en_i  in  NUM_PADS  per-pad filter enable.
- rise_en_i  in  NUM_PADS  capture rising edges into status.
- fall_en_i  in  NUM_PADS  capture falling edges into status.
- clr_i  in  NUM_PADS  one-cycle write-1-to-clear for status bits.
- filt_o  out  NUM_PADS  filtered pad level.
- rise_o  out  NUM_PADS  one-cycle pulse on a filtered rising edge.
- fall_o  out  NUM_PADS  one-cycle pulse on a filtered falling edge.
- evt_sts_o  out  NUM_PADS  sticky event status.
- irq_o  out  1  OR of evt_sts_o.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - sync flops and filt_o = RESET_VAL.
  - counters, rise_o, fall_o, evt_sts_o = 0; irq_o = 0.
- Synchroniser: a SYNC_STAGES flop chain per bit; its last stage is s[i]. It runs regardless of en_i.
- Filter, per pad i, each cycle:
  - en_i[i]=0: cnt <= 0; filt held; no pulses.
  - s[i]==filt[i]: cnt <= 0.
  - s[i]!=filt[i] and cnt >= filt_len_i: filt <= s[i]; cnt <= 0; next cycle rise_o or fall_o pulses matching the new level (registered, aligned with the filt_o change).
  - otherwise: cnt <= cnt+1. The counter saturates at all-ones and never wraps.
- Latency:
  - pad_i change to filt_o change = SYNC_STAGES + filt_len_i + 1 cycles, for a pad held stable.
  - filt_len_i=0 gives SYNC_STAGES+1.
- Glitch rejection:
  - Any s[i] pulse shorter than filt_len_i+1 cycles is discarded.
  - The counter restarts on every return to the filt level.
- filt_len_i change mid-count: the comparison uses the current value with >=. Lowering the length below the current count commits the change on the next cycle; there is no stall.
- en_i[i] 1->0 mid-count: the count is dropped. On re-enable, filtering restarts from cnt=0 against the held filt.
- Status, per bit:
  - set = (rise_o & rise_en_i) | (fall_o & fall_en_i).
  - evt_sts <= set | (evt_sts & ~clr_i).
  - Set wins over a simultaneous clear.
  - Status update is one cycle after the pulse.
- irq_o: registered, = |evt_sts_o, so it is high the same cycle evt_sts_o is nonzero.
- Reset mid-operation: all state returns to reset values immediately. No pulse is generated by reset release, even when pad_i differs from RESET_VAL; the first filtered edge appears only after full latency.

Decomposition:
- Package io_pad_pkg holds:
  - SYNC_STAGES_MIN/MAX constants;
  - typedef pad_vec_t (logic [NUM_PADS-1:0]) via a parameterised struct or localparam;
  - typedef filt_cnt_t (logic [FILT_W-1:0]).
- Sub-module io_pad_filt_cell: one pad's synchroniser, counter, filt flop and edge pulses.
  - Instantiated NUM_PADS times by a generate loop.
  - The top holds the status register and irq.

Test Plan:
- Reset with pad_i=8'hFF, RESET_VAL=0, filt_len_i=3 → after release, filt_o[i] rises at cycle 2+3+1=6, with exactly one rise_o pulse per bit; no fall_o.
- filt_len_i=4, a pad_i[0] pulse of 4 cycles → no filt_o change and no pulse. A 5-cycle stable level → filt_o[0] toggles 7 cycles after the edge.
- filt_len_i=0, pad_i[1] toggled every 2 cycles → filt_o[1] follows with 3-cycle delay; rise_o/fall_o alternate.
- rise_en_i[2]=1, fall_en_i[2]=0, pad rise then fall → evt_sts_o[2]=1 after the rise only, irq_o=1. clr_i[2] pulse → status 0, irq 0.
- clr_i[3] asserted in the same cycle a rise sets bit 3 → evt_sts_o[3] stays 1.
- en_i[4] dropped mid-count then restored → no pulse during the disable; a full filt_len_i+1 stable count is needed after re-enable. Async rst_n asserted mid-count → outputs are reset values within the same cycle.
